pipe_addsub: RTL
================

# pipe_addsub

Parametrised, pipelined adder/subtractor for the datapath. The carry chain is split into STAGES equal slices, one slice per pipeline register. Each stage has a valid/ready handshake with backpressure, and the last stage produces result flags (carry, overflow, zero). It sits between operand-select muxes and the writeback/ALU-result register wherever a long carry chain would limit clock frequency.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 2, number of pipeline stages/carry slices; 1 ≤ STAGES ≤ WIDTH
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clock clk
- in_valid  in  1  operands/op present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = a+b, 1 = a−b
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- y  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB; for sub, 1 = no borrow (a ≥ b unsigned)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  y == 0

## Operation
- Slice width SW = WIDTH/STAGES.
- Transform on accept: b_eff = sub ? ~b : b; c0 = sub.
- Stage k (0..STAGES−1):
  - adds slice k of a and b_eff plus carry from stage k−1 (c0 for k=0);
  - registers its SW result bits and the slice carry;
  - forwards the completed lower result slices, the untouched upper operand slices, the sign bits of a and b_eff, and a running "lower slices all zero" bit.
- Last stage computes:
  - cout = carry out of bit WIDTH−1;
  - ovf = (a[MSB] == b_eff[MSB]) && (y[MSB] != a[MSB]);
  - zero = running-zero AND (final slice == 0).
- Handshake per stage:
  - stage_ready[k] = !valid[k] || stage_ready[k+1];
  - stage_ready[STAGES] = out_ready;
  - in_ready = stage_ready[0].
- Stage k loads when stage_ready[k]. valid[k] takes valid[k−1] (in_valid for k=0). Payload registers load only when the incoming valid is 1.
- Transfer occurs when valid && ready on either port. There is no combinational path from in_valid to out_valid.
- While out_valid && !out_ready, y/cout/ovf/zero stay stable and the pipeline fills behind them.

## Timing
- Latency: result appears STAGES cycles after the accepting edge. STAGES=1 gives a 1-cycle registered adder.
- Throughput: 1 op/cycle when out_ready is held high.
- Capacity: exactly STAGES in-flight ops. With the pipeline full and out_ready=0, in_ready=0.
- in_ready is combinational from out_ready through the ready chain. This path is accepted.
- Reset (asynchronous): all valid bits, y, cout, ovf and zero go to 0 immediately. in_ready=1 after reset. In-flight ops are discarded, even mid-stall.
- Simultaneous pop and push on a full pipeline: both occur in the same cycle and occupancy is unchanged.
- Wrap-around: sums wrap modulo 2^WIDTH. There is no saturation.

## Structure
- Shared package pipe_addsub_pkg: op encoding constants OP_ADD=1'b0, OP_SUB=1'b1; flag bundle typedef {cout, ovf, zero}.
- One sub-module, addsub_slice: SW-bit combinational slice adder with carry in/out and slice-zero output. It is instantiated once per stage inside a generate loop.
- Stage registers live in the top level, all on clk with the asynchronous reset.

## Test plan
WIDTH=8, STAGES=2 unless noted.
- Add with out_ready=1: a=0x7F, b=0x01, sub=0 -> two cycles later y=0x80, cout=0, ovf=1, zero=0.
- Subtract to zero: a=0x35, b=0x35, sub=1 -> y=0x00, cout=1, ovf=0, zero=1. Also a=0x00, b=0x01, sub=1 -> y=0xFF, cout=0, ovf=0.
- Backpressure: hold out_ready=0 and push 3 ops -> 2 accepted, then in_ready=0. y holds the first result stable. Release out_ready -> results emerge in order with no loss or duplication.
- Streaming: 100 random ops, in_valid and out_ready both held 1 -> one result per cycle after the 2-cycle fill, matching the reference model including all flags.
- Reset mid-operation: assert reset with 2 ops in flight and out_ready=0 -> out_valid=0 and y=0 immediately, in_ready=1 after release, no stale result emitted.
- Parameter sweep: STAGES=1, 4, 8 with WIDTH=8, and WIDTH=32 with STAGES=4 -> latency equals STAGES and results match the model.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
package pipe_addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Result flags produced by the last stage
   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

endpackage

// File: rtl/pipe_addsub_slice.sv
// One carry slice: SW-bit add with carry in/out and a slice-is-zero flag.
module addsub_slice
   import pipe_addsub_pkg::*;
#(
   parameter int SW = 16
) (
   input  logic [SW-1:0] i_a,
   input  logic [SW-1:0] i_b,
   input  logic          i_ci,
   output logic [SW-1:0] o_sum,
   output logic          o_co,
   output logic          o_zero
);

   logic [SW:0] w_full;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_ci};
   assign o_sum  = w_full[SW-1:0];
   assign o_co   = w_full[SW];
   assign o_zero = (w_full[SW-1:0] == '0);

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES slices, one
// register stage per slice, each stage with its own valid/ready handshake.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW = WIDTH / STAGES;

   // Index k is the input side of stage k; index STAGES is the output port.
   wire [STAGES:0]            w_vld;
   wire [STAGES:0]            w_rdy;
   wire [STAGES:0]            w_c;
   wire [STAGES:0]            w_z;
   wire [STAGES:0][WIDTH-1:0] w_y;

   logic [WIDTH-1:0] w_beff;
   logic             w_ovf;
   flags_t           w_flags;

   assign w_beff         = (sub == OP_SUB) ? ~b : b;
   assign w_vld[0]       = in_valid;
   assign w_c[0]         = sub;
   assign w_z[0]         = 1'b1;
   assign w_y[0]         = '0;
   assign w_rdy[STAGES]  = out_ready;
   assign in_ready       = w_rdy[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      // Operand bits still to be added when entering this stage
      localparam int IW = WIDTH - k*SW;

      logic [IW-1:0]    w_ain;
      logic [IW-1:0]    w_bin;
      logic [SW-1:0]    w_sum;
      logic             w_co;
      logic             w_sz;
      logic             r_vld;
      logic             r_c;
      logic             r_z;
      logic [WIDTH-1:0] r_y;

      if (k == 0) begin : g_in
         assign w_ain = a;
         assign w_bin = w_beff;
      end else begin : g_in
         assign w_ain = g_stg[k-1].g_fwd.r_a;
         assign w_bin = g_stg[k-1].g_fwd.r_b;
      end

      addsub_slice #(.SW(SW)) u_slice (
         .i_a   (w_ain[SW-1:0]),
         .i_b   (w_bin[SW-1:0]),
         .i_ci  (w_c[k]),
         .o_sum (w_sum),
         .o_co  (w_co),
         .o_zero(w_sz)
      );

      assign w_rdy[k]   = !r_vld || w_rdy[k+1];
      assign w_vld[k+1] = r_vld;
      assign w_c[k+1]   = r_c;
      assign w_z[k+1]   = r_z;
      assign w_y[k+1]   = r_y;

      // Stage register: valid follows the upstream valid, payload only on a real op
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_vld <= 1'b0;
            r_c   <= 1'b0;
            r_z   <= 1'b0;
            r_y   <= '0;
         end else if (w_rdy[k]) begin
            r_vld <= w_vld[k];
            if (w_vld[k]) begin
               r_c <= w_co;
               r_z <= w_z[k] & w_sz;
               r_y <= w_y[k] | (WIDTH'(w_sum) << (k*SW));
            end
         end
      end

      if (k < STAGES-1) begin : g_fwd
         // Untouched upper operand slices, shifted down so slice k+1 sits at bit 0
         logic [IW-SW-1:0] r_a;
         logic [IW-SW-1:0] r_b;

         // Forward the remaining operand bits to the next stage
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_rdy[k] && w_vld[k]) begin
               r_a <= w_ain[IW-1:SW];
               r_b <= w_bin[IW-1:SW];
            end
         end
      end else begin : g_last
         logic r_ovf;

         // Signed overflow: equal operand signs but result sign differs
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_ovf <= 1'b0;
            end else if (w_rdy[k] && w_vld[k]) begin
               r_ovf <= (w_ain[SW-1] == w_bin[SW-1]) && (w_sum[SW-1] != w_ain[SW-1]);
            end
         end

         assign w_ovf = r_ovf;
      end
   end

   assign w_flags   = '{cout: w_c[STAGES], ovf: w_ovf, zero: w_z[STAGES]};
   assign out_valid = w_vld[STAGES];
   assign y         = w_y[STAGES];
   assign cout      = w_flags.cout;
   assign ovf       = w_flags.ovf;
   assign zero      = w_flags.zero;

endmodule
